// File: rtl/cordic_pkg.sv
// Shared CORDIC constants, state encoding and micro-rotation tables.
package cordic_pkg;

  localparam int DATA_W = 21;
  localparam int FRAC_W = 18;

  localparam logic LIN_ROT = 1'b0;
  localparam logic HYP_VEC = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Hyperbolic shift sequence; indices 4 and 13 repeat so the series converges.
  function automatic logic [3:0] hyp_idx(input logic [3:0] step);
    logic [3:0] r;
    if (step <= 4'd3)       r = step + 4'd1;
    else if (step <= 4'd13) r = step;
    else if (step == 4'd14) r = 4'd13;
    else                    r = 4'd14;
    return r;
  endfunction

  // Linear angle constant 2^-i in Q2.18.
  function automatic logic [DATA_W-1:0] e_lin(input logic [3:0] i);
    logic [DATA_W-1:0] r;
    r = {{(DATA_W-1){1'b0}}, 1'b1} << (FRAC_W - int'(i));
    return r;
  endfunction

  // atanh(2^-i) in Q2.18, rounded; i=0 never occurs in the hyperbolic sequence.
  function automatic logic [DATA_W-1:0] e_hyp(input logic [3:0] i);
    logic [DATA_W-1:0] r;
    case (i)
      4'd1:    r = 21'd143997;
      4'd2:    r = 21'd66955;
      4'd3:    r = 21'd32940;
      4'd4:    r = 21'd16405;
      4'd5:    r = 21'd8195;
      4'd6:    r = 21'd4096;
      4'd7:    r = 21'd2048;
      4'd8:    r = 21'd1024;
      4'd9:    r = 21'd512;
      4'd10:   r = 21'd256;
      4'd11:   r = 21'd128;
      4'd12:   r = 21'd64;
      4'd13:   r = 21'd32;
      4'd14:   r = 21'd16;
      4'd15:   r = 21'd8;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Sign-extend by one bit so a sum's carry-out can be compared with its wrap.
  function automatic logic signed [DATA_W:0] sx(input logic signed [DATA_W-1:0] v);
    return {v[DATA_W-1], v};
  endfunction

endpackage

// File: rtl/cordic_inv_stage.sv
// One combinational micro-rotation for linear rotation / hyperbolic vectoring.
module cordic_inv_stage
  import cordic_pkg::*;
(
  input  logic                     mode_i,
  input  logic [3:0]               idx_i,
  input  logic signed [DATA_W-1:0] x_i,
  input  logic signed [DATA_W-1:0] y_i,
  input  logic signed [DATA_W-1:0] z_i,
  output logic signed [DATA_W-1:0] x_o,
  output logic signed [DATA_W-1:0] y_o,
  output logic signed [DATA_W-1:0] z_o,
  output logic                     ovf_o
);

  logic signed [DATA_W-1:0] xs, ys, e;
  logic signed [DATA_W:0]   xw, yw, zw;
  logic                     dpos;

  // Direction pick, shifted terms and 22-bit sums with wrap detection.
  always_comb begin
    xs = x_i >>> idx_i;
    ys = y_i >>> idx_i;
    if (mode_i == LIN_ROT) begin
      dpos = ~z_i[DATA_W-1];
      e    = e_lin(idx_i);
    end else begin
      dpos = y_i[DATA_W-1];
      e    = e_hyp(idx_i);
    end
    xw = sx(x_i);
    if (mode_i == HYP_VEC) xw = dpos ? sx(x_i) + sx(ys) : sx(x_i) - sx(ys);
    yw = dpos ? sx(y_i) + sx(xs) : sx(y_i) - sx(xs);
    zw = dpos ? sx(z_i) - sx(e)  : sx(z_i) + sx(e);
    x_o   = xw[DATA_W-1:0];
    y_o   = yw[DATA_W-1:0];
    z_o   = zw[DATA_W-1:0];
    ovf_o = (xw[DATA_W] ^ xw[DATA_W-1]) |
            (yw[DATA_W] ^ yw[DATA_W-1]) |
            (zw[DATA_W] ^ zw[DATA_W-1]);
  end

endmodule

// File: rtl/cordic_inv_engine.sv
// Iterative CORDIC engine: linear-rotation MAC and hyperbolic-vectoring atanh.
module cordic_inv_engine #(
  parameter int ITER   = 16,
  parameter int DATA_W = 21
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mode,
  input  logic [DATA_W-1:0] x_in,
  input  logic [DATA_W-1:0] y_in,
  input  logic [DATA_W-1:0] z_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] x_out,
  output logic [DATA_W-1:0] y_out,
  output logic [DATA_W-1:0] z_out,
  output logic              ovf
);
  import cordic_pkg::*;

  localparam logic [3:0] LAST_STEP = 4'(ITER - 1);

  state_e                   state_q, state_d;
  logic [3:0]               step_q, step_d, idx;
  logic signed [DATA_W-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic signed [DATA_W-1:0] x_nx, y_nx, z_nx;
  logic                     mode_q, mode_d, ovf_q, ovf_d, st_ovf;

  assign idx = (mode_q == HYP_VEC) ? hyp_idx(step_q) : step_q;

  cordic_inv_stage u_stage (
    .mode_i (mode_q),
    .idx_i  (idx),
    .x_i    (x_q),
    .y_i    (y_q),
    .z_i    (z_q),
    .x_o    (x_nx),
    .y_o    (y_nx),
    .z_o    (z_nx),
    .ovf_o  (st_ovf)
  );

  // Next-state and datapath register updates for accept / iterate / hand-off.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    mode_d  = mode_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          x_d     = x_in;
          y_d     = y_in;
          z_d     = z_in;
          mode_d  = mode;
          ovf_d   = 1'b0;
          step_d  = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        x_d    = x_nx;
        y_d    = y_nx;
        z_d    = z_nx;
        ovf_d  = ovf_q | st_ovf;
        step_d = step_q + 4'd1;
        if (step_q == LAST_STEP) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and working registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      mode_q  <= LIN_ROT;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      mode_q  <= mode_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign x_out     = x_q;
  assign y_out     = y_q;
  assign z_out     = z_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_cordic_inv_engine.sv
// Directed bench for cordic_inv_engine: vector table plus handshake corner cases.
module tb_cordic_inv_engine;

  localparam int ITER = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        mode = 1'b0;
  logic [20:0] x_in = '0, y_in = '0, z_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [20:0] x_out, y_out, z_out;
  logic        ovf;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cordic_inv_engine #(.ITER(ITER), .DATA_W(21)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .x_in      (x_in),
    .y_in      (y_in),
    .z_in      (z_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_out     (x_out),
    .y_out     (y_out),
    .z_out     (z_out),
    .ovf       (ovf)
  );

  typedef struct {
    logic        m;
    logic [20:0] x, y, z;
    logic [20:0] ex, ey, ez;
    int          tx, ty, tz;   // tolerance in LSB, -1 = not checked
    logic        eovf;
  } vec_t;

  vec_t vecs[6];

  function automatic int sx(input logic [20:0] v);
    return int'($signed(v));
  endfunction

  task automatic chk_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic chk_tol(input string name, input logic [20:0] act, input logic [20:0] exp, input int tol);
    int d;
    d = sx(act) - sx(exp);
    if (d < 0) d = -d;
    checks++;
    if (d > tol) begin
      failures++;
      $display("FAIL %s: got 0x%05h want 0x%05h +-%0d (off by %0d)", name, act, exp, tol, d);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands for one edge; engine must be in IDLE to accept.
  task automatic start_op(input logic m, input logic [20:0] x, input logic [20:0] y, input logic [20:0] z);
    mode = m; x_in = x; y_in = y; z_in = z; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Cycles from accept to first out_valid, bounded.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    string nm;

    //          m  x         y         z         ex        ey        ez        tx  ty  tz  ovf
    vecs[0] = '{1'b0, 21'h40000, 21'h00000, 21'h20000, 21'h40000, 21'h20000, 21'h00000, 0, 16, 8, 1'b0};
    vecs[1] = '{1'b0, 21'h60000, 21'h10000, 21'h1C0000, 21'h60000, 21'h1B0000, 21'h00000, 0, 16, -1, 1'b0};
    vecs[2] = '{1'b1, 21'h40000, 21'h20000, 21'h00000, 21'h2DE6F, 21'h00000, 21'h2327D, 64, 32, 32, 1'b0};
    vecs[3] = '{1'b1, 21'h40000, 21'h1E0000, 21'h00000, 21'h2DE6F, 21'h00000, 21'h1DCD83, 64, 32, 32, 1'b0};
    vecs[4] = '{1'b0, 21'hE0000, 21'hC0000, 21'h40000, 21'hE0000, 21'h00000, 21'h00000, 0, -1, -1, 1'b1};
    vecs[5] = '{1'b0, 21'h20000, 21'h08000, 21'h30000, 21'h20000, 21'h20000, 21'h00000, 0, 16, 8, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    chk_eq("reset in_ready", int'(in_ready), 1);
    chk_eq("reset out_valid", int'(out_valid), 0);
    chk_eq("reset ovf", int'(ovf), 0);
    chk_eq("reset outputs", int'({x_out, y_out, z_out} != '0), 0);

    // Table-driven operations; vector 5 follows the overflow case to prove ovf clears.
    for (int v = 0; v < 6; v++) begin
      start_op(vecs[v].m, vecs[v].x, vecs[v].y, vecs[v].z);
      $sformat(nm, "v%0d in_ready_busy", v);
      chk_eq(nm, int'(in_ready), 0);
      wait_done(lat);
      $sformat(nm, "v%0d latency", v);
      chk_eq(nm, lat, ITER);
      if (vecs[v].tx >= 0) begin $sformat(nm, "v%0d x_out", v); chk_tol(nm, x_out, vecs[v].ex, vecs[v].tx); end
      if (vecs[v].ty >= 0) begin $sformat(nm, "v%0d y_out", v); chk_tol(nm, y_out, vecs[v].ey, vecs[v].ty); end
      if (vecs[v].tz >= 0) begin $sformat(nm, "v%0d z_out", v); chk_tol(nm, z_out, vecs[v].ez, vecs[v].tz); end
      $sformat(nm, "v%0d ovf", v);
      chk_eq(nm, int'(ovf), int'(vecs[v].eovf));
      take();
      $sformat(nm, "v%0d in_ready_after_take", v);
      chk_eq(nm, int'(in_ready), 1);
    end

    // Backpressure: result of 1.0*0.5 must hold exactly while operands churn.
    start_op(1'b0, 21'h40000, 21'h00000, 21'h20000);
    wait_done(lat);
    chk_eq("bp latency", lat, ITER);
    for (int c = 0; c < 10; c++) begin
      in_valid = c[0];
      mode = $urandom_range(0, 1);
      x_in = 21'($urandom); y_in = 21'($urandom); z_in = 21'($urandom);
      tick();
      chk_eq("bp out_valid", int'(out_valid), 1);
      chk_eq("bp in_ready", int'(in_ready), 0);
      chk_eq("bp x_out", int'(x_out), 32'h40000);
      chk_eq("bp y_out", int'(y_out), 32'h20008);
      chk_eq("bp z_out", int'(z_out), 32'h1FFFF8);
    end
    in_valid = 1'b0;
    take();
    chk_eq("bp release in_ready", int'(in_ready), 1);
    chk_eq("bp release out_valid", int'(out_valid), 0);

    // Reset at step 7 of RUN aborts cleanly.
    start_op(1'b1, 21'h40000, 21'h20000, 21'h00000);
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_eq("abort in_ready", int'(in_ready), 1);
    chk_eq("abort out_valid", int'(out_valid), 0);
    chk_eq("abort outputs", int'({x_out, y_out, z_out} != '0), 0);
    chk_eq("abort ovf", int'(ovf), 0);

    start_op(1'b0, 21'h40000, 21'h00000, 21'h20000);
    wait_done(lat);
    chk_eq("post-abort latency", lat, ITER);
    chk_tol("post-abort y_out", y_out, 21'h20000, 16);
    chk_tol("post-abort z_out", z_out, 21'h00000, 8);
    chk_eq("post-abort ovf", int'(ovf), 0);
    take();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cordic_inv_engine.md
Name: cordic_inv_engine

Overview:
- Iterative, multi-cycle CORDIC engine for the two inverse modes of our existing hyperbolic-rotation/linear-vectoring datapath.
- Linear rotation (LIN_ROT) computes multiply-accumulate: y_out = y0 + x0*z0.
- Hyperbolic vectoring (HYP_VEC) computes z_out = z0 + atanh(y0/x0) and x_out = K_h*sqrt(x0^2 - y0^2).
- One shared iteration datapath is reused over ITER cycles, with a valid/ready handshake at input and output.
- Sits beside the sinh/cosh/div engine in the math unit.

Parameters:
- ITER, 16: number of micro-rotations, legal range 1..16. The index sequences below are truncated to the first ITER entries.
- DATA_W, 21: operand width. Fixed format Q2.18 (1 sign, 2 integer, 18 fraction bits). Only 21 is supported.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operand set valid
- in_ready  out  1  engine can accept operands (high only in IDLE)
- mode  in  1  0 = LIN_ROT, 1 = HYP_VEC; sampled on accept
- x_in  in  21  signed Q2.18
- y_in  in  21  signed Q2.18
- z_in  in  21  signed Q2.18
- out_valid  out  1  result valid; held until taken
- out_ready  in  1  consumer accepts result
- x_out  out  21  signed Q2.18
- y_out  out  21  signed Q2.18
- z_out  out  21  signed Q2.18
- ovf  out  1  a 21-bit add/sub overflowed during this operation; valid with out_valid

Behaviour:
- Reset, synchronous on clk while rst=1:
  - state goes to IDLE; step counter = 0.
  - x/y/z working registers, all outputs, ovf and out_valid = 0.
  - in_ready = 1 from the first cycle after rst deasserts.
- rst during RUN or DONE aborts the operation with no result; the next accept behaves normally.
- States are IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready at edge T: load x, y, z and mode, clear ovf, step = 0, go to RUN.
- RUN:
  - in_ready = 0; one micro-rotation per cycle; step increments each cycle.
  - After the ITER-th iteration, go to DONE. out_valid is first high in the cycle after edge T+ITER, i.e. latency ITER cycles.
- DONE:
  - out_valid = 1; x_out, y_out, z_out and ovf are held stable.
  - On out_valid & out_ready: go to IDLE. out_valid drops and in_ready rises on the following cycle.
  - in_valid is ignored in RUN and DONE.
  - Throughput is one operation per ITER+2 cycles minimum.
- Shift index i(step):
  - LIN_ROT: i = step (0..15).
  - HYP_VEC: 1,2,3,4,4,5,6,7,8,9,10,11,12,13,13,14, i.e. repeats at 4 and 13 for convergence.
- LIN_ROT iteration:
  - d = +1 if z >= 0, else -1.
  - x' = x.
  - y' = y + d*(x >>> i).
  - z' = z - d*E_lin(i), where E_lin(i) = 2^(18-i).
- HYP_VEC iteration:
  - d = +1 if y < 0, else -1.
  - x' = x + d*(y >>> i).
  - y' = y + d*(x >>> i).
  - z' = z - d*E_hyp(i), where E_hyp(i) = round(atanh(2^-i)*2^18).
- Arithmetic rules:
  - Shifts are arithmetic.
  - Sums wrap at 21 bits.
  - ovf is set sticky if any update's true 22-bit result differs from its 21-bit wrapped value.
  - No gain compensation: HYP_VEC x_out carries K_h ≈ 0.82816.
- Convergence domain; outside it results are unspecified but the handshake stays correct:
  - LIN_ROT: |z0| < 2.
  - HYP_VEC: x0 > 0 and |y0/x0| < 0.80.

Decomposition:
- cordic_pkg holds:
  - mode constants LIN_ROT / HYP_VEC;
  - DATA_W and FRAC_W = 18;
  - state encoding;
  - functions hyp_idx(step), e_lin(i), e_hyp(i).
- These are shared with the existing sinh/cosh/div engine.
- One combinational sub-module, cordic_inv_stage, implements a single micro-rotation: (mode, i, x, y, z) to (x', y', z', ovf_step).
- cordic_inv_engine owns the FSM, counter and registers.

Test Plan:
- LIN_ROT multiply:
  - Stimulus: x=0x40000 (1.0), y=0, z=0x20000 (0.5).
  - Response: out_valid exactly 16 cycles after accept; y_out = 0x20000 ±16 LSB; x_out = 0x40000; |z_out| ≤ 8 LSB; ovf = 0.
- LIN_ROT negative MAC:
  - Stimulus: x=0x60000 (1.5), y=0x10000 (0.25), z=0x1C0000 (-1.0).
  - Response: y_out = 0x1B0000 (-1.25) ±16 LSB; ovf = 0.
- HYP_VEC atanh:
  - Stimulus: x=0x40000 (1.0), y=0x20000 (0.5), z=0.
  - Response: z_out ≈ 0x2327D (0.54931) ±32 LSB; x_out ≈ 0x2DE6F (0.71721) ±64 LSB; |y_out| ≤ 32 LSB.
- Backpressure:
  - Stimulus: complete an operation, then hold out_ready=0 for 10 cycles while toggling in_valid and operands.
  - Response: out_valid stays 1; outputs bit-identical; in_ready = 0; no new accept. Raising out_ready gives in_ready = 1 on the next cycle.
- Reset mid-operation:
  - Stimulus: assert rst for 1 cycle at step 7 of RUN.
  - Response: next cycle in_ready = 1, out_valid = 0, outputs = 0. A subsequent case-1 operation returns a correct result.
- Overflow:
  - Stimulus: LIN_ROT with x=0xE0000 (3.5), y=0xC0000 (3.0), z=0x40000 (1.0).
  - Response: ovf = 1 while out_valid = 1. The next in-range operation reports ovf = 0.
